arcade_sync_mixer: RTL and testbench
====================================

// Module: arcade_sync_mixer
// PURPOSE
//  Final video stage of an arcade core: normalises HSync/VSync to active-high
//  polarity, expands 4-bit or 8-bit colour to 8-bit, blanks RGB, derives DE and
//  re-times everything on the pixel enable. Feeds VGA_* to the scaler/rotator.
//  No scandoubler and no hq2x live in this block.
// PARAMETERS
//  HALF_DEPTH  0  1: R/G/B inputs are 4 bits (upper nibble replicated); 0: 8 bits
//  CNT_W       20 width of sync_fix pulse-length counters (saturating)
// PORTS
//  CLK_VIDEO   in   1   video clock, all logic on rising edge
//  reset       in   1   synchronous, active-high
//  ce_pix      in   1   pixel enable, one-cycle pulse per pixel
//  R,G,B       in   DW  colour, DW = HALF_DEPTH ? 4 : 8
//  HSync,VSync in   1   raw syncs, either polarity
//  HBlank,VBlank in 1   active-high blanking
//  gamma_wr    in   1   gamma LUT write strobe (GAMMA_EN only, else ignored)
//  gamma_addr  in   10  {chan[1:0] 0=R 1=G 2=B, index[7:0]}
//  gamma_data  in   8   LUT value
//  gamma_en    in   1   1: apply LUT to output (GAMMA_EN only)
//  CE_PIXEL    out  1   pixel enable aligned with VGA_* updates
//  VGA_R/G/B   out  8   output colour
//  VGA_HS,VGA_VS out 1  active-high syncs
//  VGA_DE      out  1   data enable
// BEHAVIOUR
//  - sync_fix per sync: 2-FF sample s1,s2; cnt clears on s1!=s2 else +1 (saturate
//    at all-ones); on s1 rise store cnt->neg, on s1 fall store cnt->pos;
//    pol <= (pos > neg); out = sync_in ^ pol. Longer level = inactive level.
//  - Reset: cnt,pos,neg,pol=0; all outputs 0; gamma LUT contents unchanged.
//  - On cycle with ce_pix=1: register hs_fix,vs_fix, DE=~(HBlank|VBlank),
//    colour = DE ? expand(x) : 0; expand(x) = HALF_DEPTH ? {x,x} : x.
//  - Latency 1 clock (2 with GAMMA_EN): VGA_* change the cycle after ce_pix;
//    CE_PIXEL = ce_pix delayed by the same latency; outputs hold between pulses.
//  - ce_pix held high: updates every cycle (no edge detection here).
//  - Equal pos/neg (e.g. 50% duty) -> pol=0, sync passed unchanged.
//  - Reset mid-frame: polarity relearned after one full high+low sync period.
// CONFIGURATION
//  - ARCADE_SYNC_MIXER_GAMMA_EN defined: 3x256x8 LUT RAM written via gamma_wr at
//    gamma_addr; when gamma_en=1 VGA_R/G/B = LUT[chan][colour] (blanked pixels
//    still 0); adds one pipeline stage to all outputs incl. syncs, DE, CE_PIXEL.
//  - Undefined: no LUT, gamma_* ports ignored, latency 1.
// STRUCTURE
//  - Package arcade_video_pkg: colour width localparams, gamma addr field slices.
//  - Sub-module sync_fix_pol (instantiated twice: HSync, VSync); rest flat.
// TESTING
//  - HSync low 20/high 300 cycles, repeated -> after 2 periods pol=1,
//    VGA_HS high for the 20-cycle pulse only.
//  - HALF_DEPTH=1, R=4'hA G=4'h5 B=4'hF, blanks 0, ce_pix -> next cycle VGA_R=AA
//    VGA_G=55 VGA_B=FF, VGA_DE=1, CE_PIXEL=1.
//  - HBlank=1 with R=4'hF -> VGA_R=0, VGA_DE=0; ce_pix=0 cycles -> outputs held.
//  - reset asserted mid-line -> next cycle all outputs 0, pol=0.
//  - GAMMA_EN: write R LUT[0x80]=0x10, gamma_en=1, R=8'h80 -> VGA_R=0x10 two
//    cycles after ce_pix; gamma_en=0 -> VGA_R=0x80.
//  - 50% duty VSync 100/100 -> pol=0, VGA_VS equals input delayed by latency.

Source files
------------

// File: rtl/arcade_video_pkg.sv
// Shared definitions for the arcade video output stage.
// Colour widths, gamma LUT address field positions and channel encoding.
package arcade_video_pkg;

  localparam int OUT_W      = 8;   // output colour width per channel
  localparam int GAMMA_AW   = 10;  // {chan[1:0], index[7:0]}
  localparam int GAMMA_IDX_MSB = 7;
  localparam int GAMMA_IDX_LSB = 0;
  localparam int GAMMA_CH_MSB  = 9;
  localparam int GAMMA_CH_LSB  = 8;

  typedef enum logic [1:0] {
    CH_R    = 2'd0,
    CH_G    = 2'd1,
    CH_B    = 2'd2,
    CH_NONE = 2'd3
  } gamma_chan_e;

  // Input colour width for a given depth setting.
  function automatic int colour_w(input int half_depth);
    return (half_depth != 0) ? 4 : 8;
  endfunction

endpackage

// File: rtl/arcade_sync_mixer_sync_fix_pol.sv
// sync_fix_pol: learns the polarity of a raw sync and normalises it to
// active-high. The longer of the two levels is taken as the inactive level.
module sync_fix_pol
  import arcade_video_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic CLK_VIDEO,
  input  logic reset,
  input  logic sync_in,
  output logic sync_out
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] neg;
  logic             pol;

  // Measure high/low level lengths with a saturating counter and compare them.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      pos <= '0;
      neg <= '0;
      pol <= 1'b0;
    end else begin
      s1 <= sync_in;
      s2 <= s1;
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
      // Rising edge closes a low phase, falling edge closes a high phase.
      if (s1 && !s2)
        neg <= cnt;
      if (!s1 && s2)
        pos <= cnt;
      pol <= (pos > neg);
    end
  end

  assign sync_out = sync_in ^ pol;

endmodule

// File: rtl/arcade_sync_mixer.sv
// arcade_sync_mixer: final video stage. Normalises syncs, expands colour to
// 8 bits, blanks, derives DE and re-times everything on ce_pix.
// Optional feature: define ARCADE_SYNC_MIXER_GAMMA_EN for a 3x256x8 gamma LUT,
// which adds one pipeline stage to every output.
module arcade_sync_mixer
  import arcade_video_pkg::*;
#(
  parameter int HALF_DEPTH = 0,
  parameter int CNT_W      = 20
) (
  input  logic                              CLK_VIDEO,
  input  logic                              reset,
  input  logic                              ce_pix,
  input  logic [colour_w(HALF_DEPTH)-1:0]   R,
  input  logic [colour_w(HALF_DEPTH)-1:0]   G,
  input  logic [colour_w(HALF_DEPTH)-1:0]   B,
  input  logic                              HSync,
  input  logic                              VSync,
  input  logic                              HBlank,
  input  logic                              VBlank,
  input  logic                              gamma_wr,
  input  logic [GAMMA_AW-1:0]               gamma_addr,
  input  logic [7:0]                        gamma_data,
  input  logic                              gamma_en,
  output logic                              CE_PIXEL,
  output logic [OUT_W-1:0]                  VGA_R,
  output logic [OUT_W-1:0]                  VGA_G,
  output logic [OUT_W-1:0]                  VGA_B,
  output logic                              VGA_HS,
  output logic                              VGA_VS,
  output logic                              VGA_DE
);

  logic             hs_fix;
  logic             vs_fix;
  logic             de_in;
  logic [OUT_W-1:0] r_x;
  logic [OUT_W-1:0] g_x;
  logic [OUT_W-1:0] b_x;

  sync_fix_pol #(.CNT_W(CNT_W)) u_hs_fix (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .sync_in   (HSync),
    .sync_out  (hs_fix)
  );

  sync_fix_pol #(.CNT_W(CNT_W)) u_vs_fix (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .sync_in   (VSync),
    .sync_out  (vs_fix)
  );

  assign de_in = ~(HBlank | VBlank);

  // 4-bit inputs replicate the nibble so full scale maps to 8'hFF.
  generate
    if (HALF_DEPTH != 0) begin : g_half
      assign r_x = {R, R};
      assign g_x = {G, G};
      assign b_x = {B, B};
    end else begin : g_full
      assign r_x = R;
      assign g_x = G;
      assign b_x = B;
    end
  endgenerate

  logic             ce1;
  logic             hs1;
  logic             vs1;
  logic             de1;
  logic [OUT_W-1:0] r1;
  logic [OUT_W-1:0] g1;
  logic [OUT_W-1:0] b1;

  // Stage 1: capture syncs, DE and blanked colour on each pixel enable.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      ce1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      de1 <= 1'b0;
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
    end else begin
      ce1 <= ce_pix;
      if (ce_pix) begin
        hs1 <= hs_fix;
        vs1 <= vs_fix;
        de1 <= de_in;
        r1  <= de_in ? r_x : '0;
        g1  <= de_in ? g_x : '0;
        b1  <= de_in ? b_x : '0;
      end
    end
  end

`ifdef ARCADE_SYNC_MIXER_GAMMA_EN
  logic [7:0] lut_r [0:255];
  logic [7:0] lut_g [0:255];
  logic [7:0] lut_b [0:255];

  logic             ce2;
  logic             hs2;
  logic             vs2;
  logic             de2;
  logic [OUT_W-1:0] r2;
  logic [OUT_W-1:0] g2;
  logic [OUT_W-1:0] b2;

  // LUT write port; contents survive reset. Channel 3 is not backed by RAM.
  always_ff @(posedge CLK_VIDEO) begin
    if (gamma_wr) begin
      case (gamma_chan_e'(gamma_addr[GAMMA_CH_MSB:GAMMA_CH_LSB]))
        CH_R:    lut_r[gamma_addr[GAMMA_IDX_MSB:GAMMA_IDX_LSB]] <= gamma_data;
        CH_G:    lut_g[gamma_addr[GAMMA_IDX_MSB:GAMMA_IDX_LSB]] <= gamma_data;
        CH_B:    lut_b[gamma_addr[GAMMA_IDX_MSB:GAMMA_IDX_LSB]] <= gamma_data;
        default: ;
      endcase
    end
  end

  // Stage 2: registered LUT lookup; blanked pixels stay black regardless of LUT.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      ce2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      de2 <= 1'b0;
      r2  <= '0;
      g2  <= '0;
      b2  <= '0;
    end else begin
      ce2 <= ce1;
      if (ce1) begin
        hs2 <= hs1;
        vs2 <= vs1;
        de2 <= de1;
        r2  <= !de1 ? '0 : (gamma_en ? lut_r[r1] : r1);
        g2  <= !de1 ? '0 : (gamma_en ? lut_g[g1] : g1);
        b2  <= !de1 ? '0 : (gamma_en ? lut_b[b1] : b1);
      end
    end
  end

  assign CE_PIXEL = ce2;
  assign VGA_HS   = hs2;
  assign VGA_VS   = vs2;
  assign VGA_DE   = de2;
  assign VGA_R    = r2;
  assign VGA_G    = g2;
  assign VGA_B    = b2;
`else
  // Gamma controls have no effect in this build.
  logic unused_gamma;
  assign unused_gamma = ^{gamma_wr, gamma_addr, gamma_data, gamma_en};

  assign CE_PIXEL = ce1;
  assign VGA_HS   = hs1;
  assign VGA_VS   = vs1;
  assign VGA_DE   = de1;
  assign VGA_R    = r1;
  assign VGA_G    = g1;
  assign VGA_B    = b1;
`endif

endmodule

// File: tb/tb_arcade_sync_mixer.sv
// Directed bench for arcade_sync_mixer: a 4-bit instance and an 8-bit
// instance share clock, reset, syncs, blanking and gamma controls.
module tb_arcade_sync_mixer;

`ifdef ARCADE_SYNC_MIXER_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic CLK_VIDEO = 1'b0;
  always #5 CLK_VIDEO = ~CLK_VIDEO;

  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [3:0] r4 = '0, g4 = '0, b4 = '0;
  logic [7:0] r8 = '0, g8 = '0, b8 = '0;
  logic       HSync = 1'b0, VSync = 1'b0, HBlank = 1'b0, VBlank = 1'b0;
  logic       gamma_wr = 1'b0;
  logic [9:0] gamma_addr = '0;
  logic [7:0] gamma_data = '0;
  logic       gamma_en = 1'b0;

  logic       ce_a, hs_a, vs_a, de_a;
  logic [7:0] vr_a, vg_a, vb_a;
  logic       ce_b, hs_b, vs_b, de_b;
  logic [7:0] vr_b, vg_b, vb_b;

  arcade_sync_mixer #(.HALF_DEPTH(1), .CNT_W(20)) u_dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ce_pix(ce_pix),
    .R(r4), .G(g4), .B(b4),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .gamma_wr(gamma_wr), .gamma_addr(gamma_addr), .gamma_data(gamma_data),
    .gamma_en(gamma_en),
    .CE_PIXEL(ce_a), .VGA_R(vr_a), .VGA_G(vg_a), .VGA_B(vb_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_DE(de_a)
  );

  arcade_sync_mixer #(.HALF_DEPTH(0), .CNT_W(20)) u_dut8 (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ce_pix(ce_pix),
    .R(r8), .G(g8), .B(b8),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .gamma_wr(gamma_wr), .gamma_addr(gamma_addr), .gamma_data(gamma_data),
    .gamma_en(gamma_en),
    .CE_PIXEL(ce_b), .VGA_R(vr_b), .VGA_G(vg_b), .VGA_B(vb_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_DE(de_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  // One ce_pix pulse, then wait until the result has reached the outputs.
  task automatic pix();
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  // Drive a sync level for n cycles with ce_pix high; compare once checking is on.
  task automatic run_sync(input bit is_v, input logic lvl, input int n, input bit do_chk);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      if (is_v) VSync = lvl; else HSync = lvl;
      tick();
      exp_q.push_back(is_v ? lvl : ~lvl);
      if (exp_q.size() >= LAT) begin
        e = exp_q.pop_front();
        if (do_chk) begin
          if (is_v) begin
            chk("vs_50pct_a", vs_a, e);
            chk("vs_50pct_b", vs_b, e);
          end else begin
            chk("hs_neg_a", hs_a, e);
            chk("hs_neg_b", hs_b, e);
          end
        end
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) tick();
    // Reset state
    chk("rst_ce", ce_a, 0);
    chk("rst_r", vr_a, 0);
    chk("rst_de", de_a, 0);
    chk("rst_hs", hs_a, 0);
    chk("rst_vs", vs_a, 0);
    chk("rst_r8", vr_b, 0);
    reset = 1'b0;
    tick();

    // Half-depth expansion, unblanked
    r4 = 4'hA; g4 = 4'h5; b4 = 4'hF;
    r8 = 8'h3C; g8 = 8'hC3; b8 = 8'h81;
    pix();
    chk("exp_r", vr_a, 8'hAA);
    chk("exp_g", vg_a, 8'h55);
    chk("exp_b", vb_a, 8'hFF);
    chk("exp_de", de_a, 1);
    chk("exp_ce", ce_a, 1);
    chk("full_r", vr_b, 8'h3C);
    chk("full_g", vg_b, 8'hC3);
    chk("full_b", vb_b, 8'h81);

    // Horizontal blanking forces black and DE low
    HBlank = 1'b1; r4 = 4'hF; r8 = 8'hFF;
    pix();
    chk("hblank_r", vr_a, 0);
    chk("hblank_g", vg_a, 0);
    chk("hblank_de", de_a, 0);
    chk("hblank_r8", vr_b, 0);

    // No pixel enable: outputs hold while inputs change
    HBlank = 1'b0; r4 = 4'h1; g4 = 4'h2; r8 = 8'h11;
    repeat (3) tick();
    chk("hold_r", vr_a, 0);
    chk("hold_de", de_a, 0);
    chk("hold_ce", ce_a, 0);
    chk("hold_r8", vr_b, 0);

    // Vertical blanking alone also blanks
    VBlank = 1'b1; r4 = 4'h7;
    pix();
    chk("vblank_de", de_a, 0);
    chk("vblank_r", vr_a, 0);
    VBlank = 1'b0;

    // ce_pix held high: every cycle updates
    ce_pix = 1'b1;
    r4 = 4'h1; tick();
    r4 = 4'h2; tick();
    r4 = 4'h3; tick();
    ce_pix = 1'b0;
    repeat (LAT - 1) tick();
    chk("cont_r", vr_a, 8'h33);
    chk("cont_de", de_a, 1);

    // Negative HSync (low 20 / high 300): learned after two periods
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete();
    ce_pix = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_sync(1'b0, 1'b0, 20, p == 2);
      run_sync(1'b0, 1'b1, 300, p == 2);
    end

    // Reset mid-line clears outputs and forgets the learned polarity
    r4 = 4'hC; HSync = 1'b1;
    reset = 1'b1;
    tick();
    chk("midrst_ce", ce_a, 0);
    chk("midrst_r", vr_a, 0);
    chk("midrst_de", de_a, 0);
    chk("midrst_hs", hs_a, 0);
    reset = 1'b0;
    repeat (LAT) tick();
    chk("postrst_hs_pol0", hs_a, 1);
    chk("postrst_r", vr_a, 8'hCC);
    chk("postrst_ce", ce_a, 1);

    // 50% duty VSync: polarity stays 0, passed through delayed
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      run_sync(1'b1, 1'b0, 100, p >= 2);
      run_sync(1'b1, 1'b1, 100, p >= 2);
    end
    ce_pix = 1'b0;
    tick();

`ifdef ARCADE_SYNC_MIXER_GAMMA_EN
    // Gamma LUT, one entry per channel at index 0x80
    gamma_wr = 1'b1;
    gamma_addr = {2'd0, 8'h80}; gamma_data = 8'h10; tick();
    gamma_addr = {2'd1, 8'h80}; gamma_data = 8'h77; tick();
    gamma_addr = {2'd2, 8'h80}; gamma_data = 8'h33; tick();
    gamma_wr = 1'b0;
    r8 = 8'h80; g8 = 8'h80; b8 = 8'h80;
    gamma_en = 1'b1;
    pix();
    chk("gamma_r", vr_b, 8'h10);
    chk("gamma_g", vg_b, 8'h77);
    chk("gamma_b", vb_b, 8'h33);
    chk("gamma_ce", ce_b, 1);
    HBlank = 1'b1;
    pix();
    chk("gamma_blank_r", vr_b, 0);
    HBlank = 1'b0;
    gamma_en = 1'b0;
    pix();
    chk("gamma_off_r", vr_b, 8'h80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
